// File: rtl/sisc_seq_if.sv
// ---------------------------------------------------------------------------
// sisc_seq_if : instruction-memory fetch bus between the sequencer and imem.
//   imem_addr  [AW-1:0]  fetch address (current PC), sequencer -> memory
//   imem_req             fetch request, sequencer -> memory
//   imem_data  [31:0]    instruction word, memory -> sequencer
//   imem_ready           imem_data valid this cycle, memory -> sequencer
// Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface sisc_seq_if #(
    parameter int unsigned AW = 16
) ();

    localparam int unsigned IW = 32;

    logic [AW-1:0] imem_addr;
    logic          imem_req;
    logic [IW-1:0] imem_data;
    logic          imem_ready;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_data,
        input  imem_ready
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_data,
        output imem_ready
    );

endinterface

// File: rtl/sisc_seq.sv
// ---------------------------------------------------------------------------
// sisc_seq : instruction sequencer for a small single-issue core.
//   Fetches a 32-bit word, decodes the opcode in ir[31:28] and steps through
//   EXECUTE / WRITEBACK for ALU ops, resolves BRA/BRR branches against the
//   status flags, and parks in HALT on HLT until reset.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_f      in   asynchronous active-low reset
//   imem       mst  fetch bus (imem_addr = PC, imem_req, imem_data, imem_ready)
//   stat[3:0]  in   status flags {C, V, N, Z}
//   ir[31:0]   out  latched instruction register
//   ex_en      out  one-cycle execute strobe (ALU ops only)
//   wb_en      out  one-cycle register-file write strobe
//   halted     out  high while in HALT
//   state[2:0] out  current FSM state code, for debug
//
// Parameters:
//   AW        instruction address width (AW <= 32)
//   RESET_PC  PC value loaded on reset
// ---------------------------------------------------------------------------
module sisc_seq #(
    parameter int unsigned    AW       = 16,
    parameter logic [AW-1:0]  RESET_PC = AW'(16'h0000)
) (
    input  logic              clk,
    input  logic              rst_f,
    sisc_seq_if.master        imem,
    input  logic [3:0]        stat,
    output logic [31:0]       ir,
    output logic              ex_en,
    output logic              wb_en,
    output logic              halted,
    output logic [2:0]        state
);

    localparam int unsigned IW  = 32;
    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_NOP = 4'h0;
    localparam logic [OPW-1:0] OP_ALU = 4'h1;
    localparam logic [OPW-1:0] OP_BRA = 4'h2;
    localparam logic [OPW-1:0] OP_BRR = 4'h3;
    localparam logic [OPW-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    state_t          state_q;
    state_t          state_next;
    logic [AW-1:0]   pc_q;
    logic [AW-1:0]   pc_next;
    logic [IW-1:0]   ir_q;
    logic [IW-1:0]   ir_next;
    logic            imem_req_q;

    logic [OPW-1:0]  opcode;
    logic [3:0]      br_mask;
    logic            br_taken;
    logic [IW-1:0]   br_rel_ext;
    logic [AW-1:0]   pc_inc;
    logic [AW-1:0]   bra_target;
    logic [AW-1:0]   brr_target;

    // Instruction fields and branch resolution, all from registered ir/pc.
    assign opcode     = ir_q[31:28];
    assign br_mask    = ir_q[27:24];
    // An all-zero mask is an unconditional branch.
    assign br_taken   = (br_mask == 4'h0) || ((stat & br_mask) != 4'h0);
    assign br_rel_ext = {{16{ir_q[15]}}, ir_q[15:0]};
    // Natural AW-bit wrap gives the modulo-2^AW PC arithmetic.
    assign pc_inc     = pc_q + AW'(1);
    assign bra_target = ir_q[AW-1:0];
    // PC has already been incremented past the branch when this is used.
    assign brr_target = pc_q + br_rel_ext[AW-1:0];

    // Next-state, next-PC and next-IR selection.
    always_comb begin
        state_next = ST_START;
        pc_next    = pc_q;
        ir_next    = ir_q;
        case (state_q)
            ST_START: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ready) begin
                    ir_next    = imem.imem_data;
                    pc_next    = pc_inc;
                    state_next = ST_DECODE;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_ALU,
                    OP_BRA,
                    OP_BRR:  state_next = ST_EXECUTE;
                    OP_HLT:  state_next = ST_HALT;
                    OP_NOP:  state_next = ST_FETCH;
                    default: state_next = ST_FETCH;
                endcase
            end
            ST_EXECUTE: begin
                if (opcode == OP_ALU) begin
                    state_next = ST_WRITEBACK;
                end else begin
                    state_next = ST_FETCH;
                    if (br_taken) begin
                        if (opcode == OP_BRA) begin
                            pc_next = bra_target;
                        end else if (opcode == OP_BRR) begin
                            pc_next = brr_target;
                        end
                    end
                end
            end
            ST_WRITEBACK: begin
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                // Unused codes 6-7 recover through START.
                state_next = ST_START;
            end
        endcase
    end

    // State, PC, IR and the registered Moore strobes.
    // Strobes are loaded from the state being entered, so each one is a pure
    // function of the registered state (and ir for ex_en) and never of inputs.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= ST_START;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            ex_en      <= 1'b0;
            wb_en      <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_q    <= state_next;
            pc_q       <= pc_next;
            ir_q       <= ir_next;
            imem_req_q <= (state_next == ST_FETCH);
            ex_en      <= (state_next == ST_EXECUTE) && (ir_next[31:28] == OP_ALU);
            wb_en      <= (state_next == ST_WRITEBACK);
            halted     <= (state_next == ST_HALT);
        end
    end

    // Output wiring of registered state.
    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = imem_req_q;
    assign ir             = ir_q;
    assign state          = state_q;

endmodule

// File: tb/tb_sisc_seq.sv
// ---------------------------------------------------------------------------
// tb_sisc_seq : bench for sisc_seq. A reference model walks each program
// instruction by instruction and queues the expected fetch / execute /
// writeback / halt events; a monitor pops and compares as the DUT shows them.
// ---------------------------------------------------------------------------
module tb_sisc_seq;

    localparam int unsigned   AW  = 16;
    localparam logic [AW-1:0] RPC = 16'h0000;

    localparam int EV_FETCH = 1;
    localparam int EV_EX    = 2;
    localparam int EV_WB    = 3;
    localparam int EV_HALT  = 4;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [3:0]  stat;
    logic [31:0] ir;
    logic        ex_en;
    logic        wb_en;
    logic        halted;
    logic [2:0]  state;

    sisc_seq_if #(.AW(AW)) bus ();

    sisc_seq #(.AW(AW), .RESET_PC(RPC)) dut (
        .clk    (clk),
        .rst_f  (rst_f),
        .imem   (bus),
        .stat   (stat),
        .ir     (ir),
        .ex_en  (ex_en),
        .wb_en  (wb_en),
        .halted (halted),
        .state  (state)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    ev_t         sb [$];
    int          n_checks    = 0;
    int          n_fail      = 0;
    int          tail_events = 0;
    int          ready_pct   = 100;
    int          stall_left  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input int kind, input logic [31:0] val, input bit tail);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
        if (tail) tail_events++;
    endfunction

    // Architectural model: k checked instructions plus a tail that keeps the
    // scoreboard ahead of the DUT until reset is applied.
    task automatic model_run(input logic [3:0] st, input int k, input int tail);
        int          pc;
        int          off;
        logic [31:0] w;
        logic [3:0]  m;
        pc = int'(RPC);
        tail_events = 0;
        for (int i = 0; i < k + tail; i++) begin
            w = mem[pc % 256];
            push(EV_FETCH, 32'(pc), i >= k);
            pc = (pc + 1) % 65536;
            if (w[31:28] == 4'h1) begin
                push(EV_EX, w, i >= k);
                push(EV_WB, w, i >= k);
            end else if (w[31:28] == 4'h2 || w[31:28] == 4'h3) begin
                m = w[27:24];
                if (m == 4'h0 || (st & m) != 4'h0) begin
                    if (w[31:28] == 4'h2) begin
                        pc = int'(w[15:0]);
                    end else begin
                        off = int'(w[15:0]);
                        if (w[15]) off = off - 65536;
                        pc = (pc + off + 65536) % 65536;
                    end
                end
            end else if (w[31:28] == 4'hF) begin
                push(EV_HALT, 32'(pc), i >= k);
                break;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int          r;
        int          off;
        logic [31:0] w;
        r = $urandom_range(0, 99);
        w = $urandom();
        if (r < 15) begin
            w[31:28] = 4'h0;
        end else if (r < 45) begin
            w[31:28] = 4'h1;
        end else if (r < 60) begin
            w[31:28] = 4'h2;
        end else if (r < 78) begin
            w[31:28] = 4'h3;
            off = int'($urandom_range(0, 40)) - 20;
            w[15:0] = 16'(off);
        end else if (r < 96) begin
            w[31:28] = 4'($urandom_range(4, 14));
        end else begin
            w[31:28] = 4'hF;
        end
        return w;
    endfunction

    task automatic mem_clear();
        for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    endtask

    // Asserts reset without any clock edge and checks the forced values.
    task automatic do_reset();
        rst_f = 1'b0;
        #1;
        sb.delete();
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", 32'(bus.imem_addr), 32'(RPC));
        check("rst_ir", ir, 32'h0);
        check("rst_strobes", {28'd0, ex_en, wb_en, bus.imem_req, halted}, 32'h0);
    endtask

    task automatic start_run(input logic [3:0] st, input int k, input int tail);
        stat = st;
        model_run(st, k, tail);
        @(posedge clk);
        #2;
        rst_f = 1'b1;
    endtask

    task automatic finish_run();
        int cyc;
        cyc = 0;
        while (sb.size() > tail_events && cyc < 5000) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        n_checks++;
        if (sb.size() > tail_events) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d events left, expected at most %0d", sb.size(), tail_events);
        end
        do_reset();
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (state !== s && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (state !== s) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: state %0d, waiting for %0d", name, state, s);
        end
    endtask

    task automatic observe(input int kind, input logic [31:0] val, input logic [2:0] st);
        ev_t e;
        check("event_state", 32'(state), 32'(st));
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: kind %0d val %h with empty scoreboard", kind, val);
        end else begin
            e = sb.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            check("event_val", val, e.val);
        end
    endtask

    // Instruction memory: responds after each rising edge, optional stalls.
    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_data = mem[bus.imem_addr[7:0]];
            if (bus.imem_req && stall_left > 0) begin
                bus.imem_ready = 1'b0;
                stall_left--;
            end else begin
                bus.imem_ready = (int'($urandom_range(0, 99)) < ready_pct);
            end
        end
    end

    // Monitor: turns DUT activity into events and checks them in order.
    initial begin
        logic hprev;
        hprev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_f !== 1'b1) begin
                hprev = 1'b0;
                continue;
            end
            if (bus.imem_req && bus.imem_ready) observe(EV_FETCH, 32'(bus.imem_addr), 3'd1);
            if (ex_en) observe(EV_EX, ir, 3'd3);
            if (wb_en) observe(EV_WB, ir, 3'd4);
            if (halted && !hprev) observe(EV_HALT, 32'(bus.imem_addr), 3'd5);
            hprev = halted;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seq_got [6];
        logic [2:0] seq_exp [6];
        int         reqc;
        logic       hold_ok;
        int         halt_ok;

        rst_f = 1'b0;
        stat  = 4'h0;
        mem_clear();
        @(posedge clk);
        #2;
        do_reset();

        // ALU instruction walks START, FETCH, DECODE, EXECUTE, WRITEBACK, FETCH.
        mem_clear();
        mem[0] = 32'h1012_0000;
        ready_pct = 100;
        start_run(4'h0, 2, 6);
        seq_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seq_got[i] = state;
        end
        for (int i = 0; i < 6; i++) check($sformatf("alu_seq_%0d", i), 32'(seq_got[i]), 32'(seq_exp[i]));
        check("alu_pc", 32'(bus.imem_addr), 32'h0001);
        finish_run();

        // Five stalled fetch cycles before the word is accepted.
        mem_clear();
        mem[0] = 32'h1ABC_0000;
        stall_left = 5;
        start_run(4'h0, 2, 6);
        reqc = 0;
        hold_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state == 3'd2) break;
            if (bus.imem_req) reqc++;
            if (state == 3'd1 && (ir !== 32'h0 || bus.imem_addr !== 16'h0000)) hold_ok = 1'b0;
        end
        check("stall_req_cycles", 32'(reqc), 32'd6);
        check("stall_hold", 32'(hold_ok), 32'd1);
        check("stall_ir", ir, 32'h1ABC_0000);
        check("stall_pc", 32'(bus.imem_addr), 32'h0001);
        finish_run();

        // Absolute branch, taken and not taken.
        mem_clear();
        mem[0] = 32'h2100_0040;
        start_run(4'b0001, 3, 6);
        wait_state(3'd2, "bra_t_dec");
        wait_state(3'd1, "bra_t_fetch");
        check("bra_taken_pc", 32'(bus.imem_addr), 32'h0040);
        finish_run();
        start_run(4'b0000, 3, 6);
        wait_state(3'd2, "bra_n_dec");
        wait_state(3'd1, "bra_n_fetch");
        check("bra_not_taken_pc", 32'(bus.imem_addr), 32'h0001);
        finish_run();

        // Unconditional jump to 0x0F, BRR back by 4, jump to 0xFFFF, wrap.
        mem_clear();
        mem[0]   = 32'h2000_000F;
        mem[15]  = 32'h3000_FFFC;
        mem[12]  = 32'h2000_FFFF;
        mem[255] = 32'h0000_0000;
        start_run(4'h0, 8, 6);
        wait_state(3'd2, "j0_dec");
        wait_state(3'd1, "j0_fetch");
        check("bra_always_pc", 32'(bus.imem_addr), 32'h000F);
        wait_state(3'd2, "brr_dec");
        check("brr_pc_inc", 32'(bus.imem_addr), 32'h0010);
        wait_state(3'd1, "brr_fetch");
        check("brr_target_pc", 32'(bus.imem_addr), 32'h000C);
        wait_state(3'd2, "j1_dec");
        wait_state(3'd1, "j1_fetch");
        check("bra_ffff_pc", 32'(bus.imem_addr), 32'hFFFF);
        wait_state(3'd2, "wrap_dec");
        check("pc_wrap", 32'(bus.imem_addr), 32'h0000);
        finish_run();

        // HLT parks the sequencer; reset mid-cycle brings it back.
        mem_clear();
        mem[0] = 32'hF000_0000;
        start_run(4'h0, 4, 0);
        wait_state(3'd5, "halt");
        halt_ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (halted === 1'b1 && bus.imem_req === 1'b0 && state === 3'd5) halt_ok++;
        end
        check("halt_20_cycles", 32'(halt_ok), 32'd20);
        #2;
        finish_run();

        // Random programs, flags and memory latency.
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 256; a++) mem[a] = rand_instr();
            ready_pct  = int'($urandom_range(30, 100));
            stall_left = 0;
            start_run(4'($urandom()), 30, 6);
            finish_run();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
